atx_power_sequencer: RTL and testbench

- Sequencer that brings up and tears down the ATX/iCE power chain.
- Serialises command frames onto the board-controller SPI input (sdo -> controller sdi) and waits for power and configuration status.
- Retries failed configuration and reports fault.
- Sits between host request logic and the board controller's command detector; shares sclk with it.

---
 rtl/atx_power_sequencer_if.sv | 24 ++
 rtl/atx_power_sequencer.sv | 244 ++++++++++++++++++++++++
 tb/tb_atx_power_sequencer.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/atx_power_sequencer_if.sv
// Host/board-controller side bundle of the ATX/iCE power sequencer.
// The master drives requests and board status; the slave returns the serial stream and status.
interface atx_power_sequencer_if;
  logic       req_up;
  logic       req_down;
  logic       cs_pgood;
  logic       ice_cdone;
  logic       sdo;
  logic       busy;
  logic       ready;
  logic       fault;
  logic [1:0] last_cmd;
  logic [1:0] retries;

  modport master (
    output req_up, req_down, cs_pgood, ice_cdone,
    input  sdo, busy, ready, fault, last_cmd, retries
  );

  modport slave (
    input  req_up, req_down, cs_pgood, ice_cdone,
    output sdo, busy, ready, fault, last_cmd, retries
  );
endinterface

// File: rtl/atx_power_sequencer.sv
// Brings the ATX supply and iCE configuration up and down by serialising command
// frames to the board controller, with bounded configuration retries and a fault state.
module atx_power_sequencer #(
  parameter int SETTLE_CYCLES = 64,
  parameter int CONF_TIMEOUT  = 1024,
  parameter int MAX_RETRIES   = 3,
  parameter int CNT_W         = 11
) (
  input logic                  sclk,
  input logic                  n_ice_reset,
  atx_power_sequencer_if.slave bus
);

  localparam logic [1:0]       CMD_RESET    = 2'b00;
  localparam logic [1:0]       CMD_POWER_ON = 2'b01;
  localparam logic [1:0]       CMD_ICE_CONF = 2'b10;
  localparam logic [4:0]       LAST_BIT     = 5'd23;
  localparam logic [CNT_W-1:0] SETTLE_LAST  = CNT_W'(SETTLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CONF_LAST    = CNT_W'(CONF_TIMEOUT - 1);

  typedef enum logic [3:0] {
    S_IDLE,
    S_TX_RST_UP,
    S_TX_PWR,
    S_WAIT_PGOOD,
    S_SETTLE,
    S_TX_CONF,
    S_WAIT_CDONE,
    S_UP,
    S_TX_RST_FAULT,
    S_FAULT,
    S_TX_RST_DOWN
  } state_t;

  // Frame layout: 8 ones, sync 010110, cmd[1], cmd[0], 8 ones.
  function automatic logic f_frame_bit(input logic [4:0] idx, input logic [1:0] cmd);
    logic b;
    b = 1'b1;
    case (idx)
      5'd8:    b = 1'b0;
      5'd9:    b = 1'b1;
      5'd10:   b = 1'b0;
      5'd11:   b = 1'b1;
      5'd12:   b = 1'b1;
      5'd13:   b = 1'b0;
      5'd14:   b = cmd[1];
      5'd15:   b = cmd[0];
      default: b = 1'b1;
    endcase
    return b;
  endfunction

  function automatic logic [1:0] f_sat_inc(input logic [1:0] v);
    return (v == 2'b11) ? v : v + 2'd1;
  endfunction

  function automatic logic f_retry_allowed(input logic [1:0] v);
    return int'(v) < MAX_RETRIES;
  endfunction

  state_t           r_state;
  logic [CNT_W-1:0] r_cnt;
  logic [1:0]       r_retries;
  logic             r_down_pend;

  logic             r_tx_active;
  logic [4:0]       r_bit_idx;
  logic [1:0]       r_tx_cmd;
  logic             r_sdo;
  logic [1:0]       r_last_cmd;

  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic [1:0]       w_retries_nxt;
  logic             w_down_pend_nxt;
  logic             w_tx_start;
  logic [1:0]       w_tx_cmd;
  logic             w_go_down;
  logic             w_fail;
  logic             w_down;
  logic             w_tx_done;
  logic [4:0]       w_bit_nxt;
  logic             w_at_rest;

  // A power-down request seen mid-frame is remembered until the frame ends.
  assign w_down    = bus.req_down | r_down_pend;
  assign w_tx_done = r_tx_active && (r_bit_idx == LAST_BIT);
  assign w_bit_nxt = r_bit_idx + 5'd1;

  // Frame shifter: a start on the last bit chains the next frame with no idle gap.
  always_ff @(posedge sclk or posedge n_ice_reset) begin
    if (n_ice_reset) begin
      r_tx_active <= 1'b0;
      r_bit_idx   <= 5'd0;
      r_tx_cmd    <= CMD_RESET;
      r_sdo       <= 1'b1;
      r_last_cmd  <= CMD_RESET;
    end else if (w_tx_start) begin
      r_tx_active <= 1'b1;
      r_bit_idx   <= 5'd0;
      r_tx_cmd    <= w_tx_cmd;
      r_sdo       <= f_frame_bit(5'd0, w_tx_cmd);
    end else if (w_tx_done) begin
      r_tx_active <= 1'b0;
      r_bit_idx   <= 5'd0;
      r_sdo       <= 1'b1;
    end else if (r_tx_active) begin
      r_bit_idx <= w_bit_nxt;
      r_sdo     <= f_frame_bit(w_bit_nxt, r_tx_cmd);
      if (w_bit_nxt == LAST_BIT) r_last_cmd <= r_tx_cmd;
    end
  end

  always_ff @(posedge sclk or posedge n_ice_reset) begin
    if (n_ice_reset) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_retries   <= 2'b00;
      r_down_pend <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_retries   <= w_retries_nxt;
      r_down_pend <= w_down_pend_nxt;
    end
  end

  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_retries_nxt   = r_retries;
    w_down_pend_nxt = 1'b0;
    w_tx_start      = 1'b0;
    w_tx_cmd        = CMD_RESET;
    w_go_down       = 1'b0;
    w_fail          = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (bus.req_up && !bus.req_down) begin
          w_tx_start  = 1'b1;
          w_tx_cmd    = CMD_RESET;
          w_state_nxt = S_TX_RST_UP;
        end
      end
      S_TX_RST_UP, S_TX_PWR, S_TX_CONF, S_TX_RST_FAULT: begin
        if (!w_tx_done) begin
          w_down_pend_nxt = w_down;
        end else if (w_down) begin
          w_go_down = 1'b1;
        end else begin
          case (r_state)
            S_TX_RST_UP: begin
              w_tx_start  = 1'b1;
              w_tx_cmd    = CMD_POWER_ON;
              w_state_nxt = S_TX_PWR;
            end
            S_TX_PWR:  w_state_nxt = S_WAIT_PGOOD;
            S_TX_CONF: begin
              w_cnt_nxt   = '0;
              w_state_nxt = S_WAIT_CDONE;
            end
            default:   w_state_nxt = S_FAULT;
          endcase
        end
      end
      S_WAIT_PGOOD: begin
        if (w_down) begin
          w_go_down = 1'b1;
        end else if (bus.cs_pgood) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_SETTLE;
        end
      end
      S_SETTLE: begin
        if (w_down) begin
          w_go_down = 1'b1;
        end else if (!bus.cs_pgood) begin
          w_cnt_nxt   = '0;
          w_state_nxt = S_WAIT_PGOOD;
        end else if (r_cnt == SETTLE_LAST) begin
          w_tx_start  = 1'b1;
          w_tx_cmd    = CMD_ICE_CONF;
          w_state_nxt = S_TX_CONF;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_WAIT_CDONE: begin
        if (w_down) begin
          w_go_down = 1'b1;
        end else if (bus.ice_cdone) begin
          w_state_nxt = S_UP;
        end else if (r_cnt == CONF_LAST) begin
          w_fail = 1'b1;
        end else begin
          w_cnt_nxt = r_cnt + CNT_W'(1);
        end
      end
      S_UP: begin
        if (w_down) begin
          w_go_down = 1'b1;
        end else if (!bus.ice_cdone) begin
          w_fail = 1'b1;
        end
      end
      S_FAULT: begin
        if (w_down) w_go_down = 1'b1;
      end
      S_TX_RST_DOWN: begin
        if (w_tx_done) w_state_nxt = S_IDLE;
      end
      default: w_state_nxt = S_IDLE;
    endcase

    // Power-down outranks a configuration failure raised on the same cycle.
    if (w_go_down) begin
      w_tx_start      = 1'b1;
      w_tx_cmd        = CMD_RESET;
      w_state_nxt     = S_TX_RST_DOWN;
      w_retries_nxt   = 2'b00;
      w_cnt_nxt       = '0;
      w_down_pend_nxt = 1'b0;
    end else if (w_fail) begin
      w_tx_start = 1'b1;
      w_tx_cmd   = CMD_RESET;
      if (f_retry_allowed(r_retries)) begin
        w_retries_nxt = f_sat_inc(r_retries);
        w_state_nxt   = S_TX_RST_UP;
      end else begin
        w_state_nxt = S_TX_RST_FAULT;
      end
    end
  end

  assign w_at_rest    = (r_state == S_IDLE) || (r_state == S_UP) || (r_state == S_FAULT);
  assign bus.sdo      = r_sdo;
  assign bus.busy     = r_tx_active || !w_at_rest;
  assign bus.ready    = (r_state == S_UP);
  assign bus.fault    = (r_state == S_FAULT);
  assign bus.last_cmd = r_last_cmd;
  assign bus.retries  = r_retries;

endmodule

// File: tb/tb_atx_power_sequencer.sv
// Directed bench for atx_power_sequencer: a table of request/status phases with
// expected frames and outputs, plus hand-written mid-frame power-down and async reset cases.
module tb_atx_power_sequencer;

  localparam int W_FIXED  = 0;
  localparam int W_FRAMES = 1;

  logic sclk        = 1'b0;
  logic n_ice_reset = 1'b1;

  atx_power_sequencer_if bus ();

  atx_power_sequencer #(
    .SETTLE_CYCLES (4),
    .CONF_TIMEOUT  (16),
    .MAX_RETRIES   (3),
    .CNT_W         (11)
  ) dut (
    .sclk        (sclk),
    .n_ice_reset (n_ice_reset),
    .bus         (bus)
  );

  always #5 sclk = ~sclk;

  int n_chk = 0;
  int n_err = 0;

  // Detector-equivalent monitor: oldest bit at mon_win[23]; logs each complete frame.
  logic [23:0] mon_win = '1;
  logic [1:0]  mon_cmd;
  logic [1:0]  mon_log[$];
  int          zeros_seen = 0;
  int          zeros_acct = 0;

  always @(negedge sclk) begin
    if (n_ice_reset) begin
      mon_win    = '1;
      zeros_seen = 0;
      zeros_acct = 0;
    end else begin
      mon_win = {mon_win[22:0], bus.sdo};
      if (bus.sdo == 1'b0) zeros_seen++;
      if (mon_win[23:16] == 8'hFF && mon_win[15:10] == 6'b010110 && mon_win[7:0] == 8'hFF) begin
        mon_cmd = mon_win[9:8];
        mon_log.push_back(mon_cmd);
        zeros_acct += 3 + (mon_cmd[1] ? 0 : 1) + (mon_cmd[0] ? 0 : 1);
        n_chk++;
        if (bus.last_cmd !== mon_cmd) begin
          n_err++;
          $display("FAIL last_cmd_at_trailer: got %b expected %b", bus.last_cmd, mon_cmd);
        end
      end
    end
  end

  typedef struct {
    logic       up, down, pgood, cdone;
    int         kind;
    int         cycles;
    int         nfr;
    logic [15:0] frames;
    logic       ready, fault, busy;
    logic [1:0] last, retries;
    logic       chk_line;
  } step_t;

  step_t tbl[$];

  function automatic step_t mk(input logic up, down, pgood, cdone, input int kind, cycles, nfr,
                               input logic [15:0] frames, input logic ready, fault, busy,
                               input logic [1:0] last, retries, input logic chk_line);
    step_t s;
    s.up = up; s.down = down; s.pgood = pgood; s.cdone = cdone;
    s.kind = kind; s.cycles = cycles; s.nfr = nfr; s.frames = frames;
    s.ready = ready; s.fault = fault; s.busy = busy;
    s.last = last; s.retries = retries; s.chk_line = chk_line;
    return s;
  endfunction

  task automatic tick();
    @(posedge sclk);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [1:0] get_log(input int idx);
    if (idx < mon_log.size()) return mon_log[idx];
    return 2'bxx;
  endfunction

  task automatic check_outs(input string tag, input logic ready, fault, busy,
                            input logic [1:0] last, retries);
    check({tag, "_ready"},    32'(bus.ready),    32'(ready));
    check({tag, "_fault"},    32'(bus.fault),    32'(fault));
    check({tag, "_busy"},     32'(bus.busy),     32'(busy));
    check({tag, "_last_cmd"}, 32'(bus.last_cmd), 32'(last));
    check({tag, "_retries"},  32'(bus.retries),  32'(retries));
  endtask

  task automatic check_line(input string tag);
    check({tag, "_stray_zeros"}, 32'(zeros_seen), 32'(zeros_acct));
    check({tag, "_sdo_idle"},    32'(bus.sdo),    32'd1);
  endtask

  task automatic wait_log(input int target, input int budget, input string tag);
    int k = 0;
    while (mon_log.size() < target && k < budget) begin
      tick();
      k++;
    end
    check({tag, "_frames"}, 32'(mon_log.size()), 32'(target));
  endtask

  task automatic run_step(input int i, input step_t s);
    int    base;
    int    k;
    string tag;
    tag = $sformatf("step%0d", i);
    bus.req_up    = s.up;
    bus.req_down  = s.down;
    bus.cs_pgood  = s.pgood;
    bus.ice_cdone = s.cdone;
    base = mon_log.size();
    if (s.kind == W_FIXED) begin
      repeat (s.cycles) tick();
    end else begin
      k = 0;
      while (mon_log.size() < base + s.nfr && k < s.cycles) begin
        tick();
        k++;
      end
    end
    check({tag, "_nframes"}, 32'(mon_log.size() - base), 32'(s.nfr));
    for (int j = 0; j < s.nfr; j++)
      check($sformatf("%s_frame%0d", tag, j), 32'(get_log(base + j)), 32'(s.frames[2*j +: 2]));
    check_outs(tag, s.ready, s.fault, s.busy, s.last, s.retries);
    if (s.chk_line) check_line(tag);
  endtask

  initial begin
    int base;

    bus.req_up    = 1'b0;
    bus.req_down  = 1'b0;
    bus.cs_pgood  = 1'b0;
    bus.ice_cdone = 1'b0;

    //        up down pg  cd  kind      cyc nfr frames   rdy flt bsy last   retr   line
    tbl.push_back(mk(1, 0, 0, 0, W_FIXED,  10, 0, 16'h0000, 0, 0, 1, 2'b00, 2'd0, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 150, 3, 16'h0024, 0, 0, 1, 2'b10, 2'd0, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FIXED,  4, 0, 16'h0000, 0, 0, 1, 2'b10, 2'd0, 0));
    tbl.push_back(mk(1, 0, 1, 1, W_FIXED,  3, 0, 16'h0000, 1, 0, 0, 2'b10, 2'd0, 1));
    // lost cdone in UP with supply also dropped: retry parks in WAIT_PGOOD
    tbl.push_back(mk(1, 0, 0, 0, W_FRAMES, 100, 2, 16'h0004, 0, 0, 1, 2'b01, 2'd1, 0));
    tbl.push_back(mk(1, 0, 0, 0, W_FIXED,  30, 0, 16'h0000, 0, 0, 1, 2'b01, 2'd1, 1));
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 100, 1, 16'h0002, 0, 0, 1, 2'b10, 2'd1, 0));
    tbl.push_back(mk(1, 0, 1, 1, W_FIXED,  3, 0, 16'h0000, 1, 0, 0, 2'b10, 2'd1, 1));
    tbl.push_back(mk(0, 0, 1, 1, W_FIXED,  2, 0, 16'h0000, 1, 0, 0, 2'b10, 2'd1, 0));
    tbl.push_back(mk(1, 0, 1, 1, W_FIXED,  10, 0, 16'h0000, 1, 0, 0, 2'b10, 2'd1, 1));
    // req_down together with req_up from UP, then both held in IDLE
    tbl.push_back(mk(1, 1, 1, 1, W_FRAMES, 60, 1, 16'h0000, 0, 0, 0, 2'b00, 2'd0, 0));
    tbl.push_back(mk(1, 1, 1, 1, W_FIXED,  10, 0, 16'h0000, 0, 0, 0, 2'b00, 2'd0, 1));
    tbl.push_back(mk(0, 0, 1, 0, W_FIXED,  2, 0, 16'h0000, 0, 0, 0, 2'b00, 2'd0, 0));
    // configuration never completes: four ICE_CONF attempts then FAULT
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 150, 3, 16'h0024, 0, 0, 1, 2'b10, 2'd0, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 200, 3, 16'h0024, 0, 0, 1, 2'b10, 2'd1, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 200, 3, 16'h0024, 0, 0, 1, 2'b10, 2'd2, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 200, 3, 16'h0024, 0, 0, 1, 2'b10, 2'd3, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FRAMES, 100, 1, 16'h0000, 0, 1, 0, 2'b00, 2'd3, 1));
    tbl.push_back(mk(0, 0, 1, 0, W_FIXED,  3, 0, 16'h0000, 0, 1, 0, 2'b00, 2'd3, 0));
    tbl.push_back(mk(1, 0, 1, 0, W_FIXED,  20, 0, 16'h0000, 0, 1, 0, 2'b00, 2'd3, 1));
    tbl.push_back(mk(1, 1, 1, 0, W_FRAMES, 60, 1, 16'h0000, 0, 0, 0, 2'b00, 2'd0, 0));
    tbl.push_back(mk(0, 0, 1, 0, W_FIXED,  3, 0, 16'h0000, 0, 0, 0, 2'b00, 2'd0, 1));

    repeat (3) @(posedge sclk);
    #1;
    check("rst_sdo", 32'(bus.sdo), 32'd1);
    check_outs("rst", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
    n_ice_reset = 1'b0;

    for (int i = 0; i < tbl.size(); i++) run_step(i, tbl[i]);

    // req_down raised while bit 15 of POWER_ON is on the line
    base = mon_log.size();
    bus.req_up   = 1'b1;
    bus.cs_pgood = 1'b0;
    bus.ice_cdone = 1'b0;
    wait_log(base + 1, 100, "mid_first");
    repeat (15) tick();
    bus.req_down = 1'b1;
    tick();
    bus.req_down = 1'b0;
    bus.req_up   = 1'b0;
    wait_log(base + 3, 100, "mid_down");
    check("mid_frame0", 32'(get_log(base)),     32'(2'b00));
    check("mid_frame1", 32'(get_log(base + 1)), 32'(2'b01));
    check("mid_frame2", 32'(get_log(base + 2)), 32'(2'b00));
    check_outs("mid", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
    check_line("mid");
    repeat (10) tick();
    check("mid_quiet_frames", 32'(mon_log.size()), 32'(base + 3));
    check("mid_quiet_busy",   32'(bus.busy),       32'd0);

    // asynchronous reset in the middle of the ICE_CONF sync field
    base = mon_log.size();
    bus.req_up = 1'b1;
    wait_log(base + 2, 150, "ar_bringup");
    bus.cs_pgood = 1'b1;
    repeat (15) tick();
    check("ar_pre_sdo",  32'(bus.sdo),      32'd0);
    check("ar_pre_last", 32'(bus.last_cmd), 32'(2'b01));
    check("ar_pre_busy", 32'(bus.busy),     32'd1);
    #2;
    n_ice_reset = 1'b1;
    #1;
    check("ar_now_sdo", 32'(bus.sdo), 32'd1);
    check_outs("ar_now", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);
    bus.req_up   = 1'b0;
    bus.cs_pgood = 1'b0;
    #3;
    n_ice_reset = 1'b0;
    repeat (40) tick();
    check("ar_no_resume_zeros",  32'(zeros_seen),     32'd0);
    check("ar_no_resume_frames", 32'(mon_log.size()), 32'(base + 2));
    check("ar_after_sdo",        32'(bus.sdo),        32'd1);
    check_outs("ar_after", 1'b0, 1'b0, 1'b0, 2'b00, 2'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog");
  end

endmodule
